// File: rtl/imem_loader_fetch_pkg.sv
// Shared types and constants for the instruction-memory loader/fetch block.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP      = 32'h0000_0000;
  localparam logic [31:0] IMEM_RESET_PC = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
  } fetch_rsp_t;

  // True when the packer would be left holding a partial word after this cycle.
  function automatic logic partial_after(input logic [1:0] idx, input logic accept);
    logic [1:0] idx_next;
    idx_next = idx + 2'(accept);
    return idx_next != 2'd0;
  endfunction

endpackage

// File: rtl/imem_loader_fetch_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words; first byte lands in bits 31:24.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word,
  output logic [1:0]  byte_idx
);

  logic [23:0] hold;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_idx <= 2'd0;
      hold     <= 24'd0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      hold     <= {hold[15:0], byte_in};
    end
  end

  // The completed word includes the byte being accepted this cycle.
  assign word_done = accept && (byte_idx == 2'd3);
  assign word      = {hold, byte_in};

endmodule

// File: rtl/imem_loader_fetch.sv
// Instruction memory: byte-stream program loader plus registered single-cycle fetch port.
//
// state | meaning
// IDLE  | after reset, waiting for a load request
// LOAD  | accepting program bytes into memory
// RUN   | answering CPU fetches from the loaded words
module imem_loader_fetch
  import imem_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  output logic          load_ready,
  output logic          load_err,
  output logic [AW:0]   word_count,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          fault
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  imem_state_t state, state_nxt;

  logic          accept;
  logic          enter_load;
  logic          exit_load;
  logic          overflow;
  logic          partial_exit;
  logic          word_done;
  logic [31:0]   packed_word;
  logic [1:0]    byte_idx;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] waddr;
  fetch_rsp_t    rsp_d, rsp_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_en)  state_nxt = LOAD;
      LOAD:    if (!load_en) state_nxt = RUN;
      RUN:     if (load_en)  state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == LOAD) && (word_count < FULL_COUNT);
  end

  assign accept       = load_valid && load_ready;
  assign enter_load   = (state != LOAD) && load_en;
  assign exit_load    = (state == LOAD) && !load_en;
  assign overflow     = (state == LOAD) && load_valid && (word_count == FULL_COUNT);
  assign partial_exit = exit_load && partial_after(byte_idx, accept);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .clear     (enter_load || exit_load),
    .byte_in   (load_byte),
    .word_done (word_done),
    .word      (packed_word),
    .byte_idx  (byte_idx)
  );

  always_ff @(posedge clk) begin
    if (rst || enter_load) begin
      word_count <= '0;
      load_err   <= 1'b0;
    end else begin
      if (word_done)                word_count <= word_count + 1'b1;
      if (overflow || partial_exit) load_err   <= 1'b1;
    end
  end

  // Contents survive reset; fetches beyond word_count never see stale words.
  always_ff @(posedge clk) begin
    if (word_done) mem[word_count[AW-1:0]] <= packed_word;
  end

  assign waddr = pc[AW+1:2];

  always_comb begin
    rsp_d = '{instr: IMEM_NOP, valid: 1'b0, fault: 1'b0};
    if (state == RUN) begin
      if (pc == IMEM_RESET_PC) begin
        rsp_d.fault = 1'b0;
      end else if (pc[1:0] != 2'b00) begin
        rsp_d.fault = 1'b1;
      end else if ((pc[31:AW+2] != '0) || ({1'b0, waddr} >= word_count)) begin
        rsp_d.fault = 1'b1;
      end else begin
        rsp_d.instr = mem[waddr];
        rsp_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_q <= '{instr: IMEM_NOP, valid: 1'b0, fault: 1'b0};
    else     rsp_q <= rsp_d;
  end

  // A response sampled in the last RUN cycle must not leak into LOAD.
  assign instr       = (state == RUN) ? rsp_q.instr : IMEM_NOP;
  assign instr_valid = (state == RUN) && rsp_q.valid;
  assign fault       = (state == RUN) && rsp_q.fault;

endmodule

// File: tb/tb_imem_loader_fetch.sv
// Scoreboard bench: stimulus pushes model-predicted output snapshots, a monitor pops and compares.
module tb_imem_loader_fetch;
  import imem_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_ready;
  logic          load_err;
  logic [AW:0]   word_count;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          fault;

  always #5 clk = ~clk;

  imem_loader_fetch #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_valid  (load_valid),
    .load_byte   (load_byte),
    .load_ready  (load_ready),
    .load_err    (load_err),
    .word_count  (word_count),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] instr;
    logic        iv;
    logic        fault;
    logic        ready;
    logic        err;
    logic [AW:0] wc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state
  logic [31:0]  m_mem [DEPTH];
  int           m_mode = M_IDLE;
  int unsigned  m_count = 0;
  bit           m_err = 1'b0;
  logic [7:0]   m_part[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (e.due != cyc) begin
        miscompares++;
        $display("FAIL stale_expectation due=%0d now=%0d", e.due, cyc);
      end else if (instr !== e.instr || instr_valid !== e.iv || fault !== e.fault ||
                   word_count !== e.wc || load_err !== e.err || load_ready !== e.ready) begin
        miscompares++;
        $display("FAIL snapshot cyc=%0d got/exp instr=%h/%h valid=%b/%b fault=%b/%b wc=%0d/%0d err=%b/%b ready=%b/%b",
                 cyc, instr, e.instr, instr_valid, e.iv, fault, e.fault,
                 word_count, e.wc, load_err, e.err, load_ready, e.ready);
      end
    end
  end

  task automatic fetch_model(input logic [31:0] p, output logic [31:0] i, output logic v, output logic f);
    i = 32'h0; v = 1'b0; f = 1'b0;
    if (p == 32'hFFFF_FFFC)        f = 1'b0;
    else if (p % 4 != 0)           f = 1'b1;
    else if ((p / 4) >= m_count)   f = 1'b1;
    else begin
      i = m_mem[p / 4];
      v = 1'b1;
    end
  endtask

  task automatic step(input bit r, input bit en, input bit v, input logic [7:0] b, input logic [31:0] p);
    exp_t        e;
    int          pre;
    logic [31:0] fi;
    logic        fv, ff;
    rst = r; load_en = en; load_valid = v; load_byte = b; pc = p;
    pre = m_mode;
    fetch_model(p, fi, fv, ff);
    if (r) begin
      m_mode = M_IDLE; m_count = 0; m_err = 1'b0; m_part.delete();
    end else begin
      case (pre)
        M_IDLE, M_RUN: if (en) begin
          m_mode = M_LOAD; m_count = 0; m_err = 1'b0; m_part.delete();
        end
        M_LOAD: begin
          if (v) begin
            if (m_count == DEPTH) m_err = 1'b1;
            else begin
              m_part.push_back(b);
              if (m_part.size() == 4) begin
                m_mem[m_count] = {m_part[0], m_part[1], m_part[2], m_part[3]};
                m_count++;
                m_part.delete();
              end
            end
          end
          if (!en) begin
            if (m_part.size() != 0) m_err = 1'b1;
            m_part.delete();
            m_mode = M_RUN;
          end
        end
        default: ;
      endcase
    end
    if (!r && pre == M_RUN && m_mode == M_RUN) begin
      e.instr = fi; e.iv = fv; e.fault = ff;
    end else begin
      e.instr = 32'h0; e.iv = 1'b0; e.fault = 1'b0;
    end
    e.ready = (m_mode == M_LOAD) && (m_count < DEPTH);
    e.err   = m_err;
    e.wc    = (AW + 1)'(m_count);
    e.due   = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit en, input bit v, input logic [7:0] b, input logic [31:0] p);
    step(1'b0, en, v, b, p);
  endtask

  task automatic run_fetch(input logic [31:0] p);
    drive(1'b0, 1'b0, 8'h00, p);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    case ($urandom_range(0, 4))
      0:       p = 32'hFFFF_FFFC;
      1:       p = 32'($urandom_range(0, DEPTH * 4 + 7));
      2:       p = 32'($urandom_range(0, DEPTH + 1)) << 2;
      3:       p = $urandom;
      default: p = 32'($urandom_range(0, DEPTH - 1)) << 2;
    endcase
    return p;
  endfunction

  initial begin
    rst = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_byte = 8'h00; pc = 32'h0;
    @(posedge clk); #1;

    // Reset values
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);

    // Two words, then fetch both
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, 8'(i), 32'h0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    run_fetch(32'h0);
    run_fetch(32'h4);
    run_fetch(32'h8);

    // Reset then RUN: pre-fetch address and misaligned pc
    step(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    run_fetch(32'hFFFF_FFFC);
    run_fetch(32'h2);
    run_fetch(32'h0);

    // Overflow: 17 bytes into a 4-word memory
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b1, 8'(8'h10 + i), 32'h0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    run_fetch(32'd16);
    run_fetch(32'd12);
    run_fetch(32'd0);

    // Partial word at load end
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'(8'h40 + i), 32'h0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    run_fetch(32'h4);
    run_fetch(32'h0);

    // Reset mid-load, then reload from zero
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'(8'h60 + i), 32'h0);
    step(1'b1, 1'b1, 1'b1, 8'h77, 32'h0);
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'(8'h70 + i), 32'h0);
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    run_fetch(32'h0);

    // 4th byte coincides with load_en falling
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b1, 8'hAA, 32'h0);
    drive(1'b1, 1'b1, 8'hBB, 32'h0);
    drive(1'b1, 1'b1, 8'hCC, 32'h0);
    drive(1'b0, 1'b1, 8'hDD, 32'h0);
    run_fetch(32'h0);
    run_fetch(32'h4);

    // Randomized sessions
    for (int s = 0; s < 60; s++) begin
      int nbytes;
      nbytes = $urandom_range(0, 4 * DEPTH + 3);
      drive(1'b1, 1'b0, 8'h00, rand_pc());
      for (int i = 0; i < nbytes; i++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, 8'($urandom), rand_pc());
        if ($urandom_range(0, 40) == 0) step(1'b1, 1'b1, 1'b1, 8'($urandom), rand_pc());
        else drive(1'b1, 1'b1, 8'($urandom), rand_pc());
      end
      drive(1'b0, $urandom_range(0, 1) == 1, 8'($urandom), rand_pc());
      for (int i = 0; i < 10; i++) run_fetch(rand_pc());
    end

    run_fetch(32'h0);
    repeat (3) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
